fifo: RTL and testbench
=======================

FIFO -- requirements
Module: fifo

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: data word width in bits, positional parameter 1.
REQ-002 The module SHALL have parameter DEPTH, default 32: storage slots, positional parameter 2; power of two, at least 4.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port empty, output, 1 bit: high when no words are stored.
REQ-006 The module SHALL have port full, output, 1 bit: high when DEPTH-1 words are stored.
REQ-007 The module SHALL have port count, output, $clog2(DEPTH) bits: number of stored words.
REQ-008 The module SHALL have port rd, input, 1 bit: read request.
REQ-009 The module SHALL have port dout, output, WIDTH bits: registered read data.
REQ-010 The module SHALL have port wr, input, 1 bit: write request.
REQ-011 The module SHALL have port din, input, WIDTH bits: write data.

Function
REQ-012 The FIFO SHALL be a circular buffer with a write pointer and a read pointer, each $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0 naturally.
- Usable capacity: DEPTH-1 words; one slot always stays unused.
REQ-013 A write SHALL be accepted at a rising edge when wr=1 and full=0.
- Accepted write: store din at the write pointer, then increment the write pointer.
- wr=1 while full=1: ignored; no state change; no error flag.
REQ-014 A read SHALL be accepted at a rising edge when rd=1 and empty=0.
- Accepted read: load dout with the word at the read pointer in that same edge, then increment the read pointer.
- Read latency: data is valid immediately after the accepting edge.
REQ-015 dout SHALL hold its last value when no read is accepted, including rd=1 while empty=1.
REQ-016 Data order SHALL be strict first-in first-out.
REQ-017 count SHALL update per accepted operation:
- +1 for write only.
- -1 for read only.
- unchanged for both or neither.
REQ-018 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH-1), decoded from registered state so both are valid right after each edge.
REQ-019 Simultaneous rd=1 and wr=1 SHALL be judged on the pre-edge flags:
- Neither full nor empty: both accepted, count unchanged.
- empty=1: only the write is accepted.
- full=1: only the read is accepted.
REQ-020 A write into an empty FIFO SHALL NOT bypass to dout; the word is readable from the next edge onward.

Reset
REQ-021 While rst=1 the design SHALL force its registered state immediately, without waiting for a clock edge:
- Write pointer, read pointer, count and dout: 0.
- empty: 1.
- full: 0.
REQ-022 Storage contents SHALL NOT be reset.
REQ-023 Assertion of rst mid-operation SHALL discard all stored words.
REQ-024 After rst deasserts, the first rising edge SHALL accept operations normally.

Structure
REQ-025 No shared package SHALL be required; WIDTH and DEPTH are the only constants.
REQ-026 Storage SHALL be a single sub-module fifo_ram:
- Simple dual-port array of DEPTH x WIDTH.
- One synchronous write port.
- One synchronous registered read port with read enable.
REQ-027 Pointer, count and flag logic SHALL reside in fifo.

Verification
REQ-028 Reset check: rst high then low, no rd/wr -> empty=1, full=0, count=0, dout=0.
REQ-029 Fill check: 31 pushes of values 0..30 on consecutive edges (default params) -> count steps 1..31, full=1 only after the 31st write, empty=0 after the first.
REQ-030 Overflow check: a further push of 99 while full -> count stays 31, data order unchanged.
REQ-031 Drain check: 31 pops -> dout equals 0..30 in order, each valid immediately after its edge; empty=1 after the last pop; a further pop leaves dout=30.
REQ-032 Wrap check: repeat fill and drain three times so both pointers wrap -> data still 0..30 in order, flags correct.
REQ-033 Simultaneous check: with 5 words stored, rd=wr=1 for 10 edges -> count stays 5, FIFO order preserved.
- Also with empty=1: count becomes 1, dout unchanged.
- Also with full=1: count becomes 30.

Source files
------------

// File: rtl/fifo_ram.sv
// Simple dual-port DEPTH x WIDTH storage: one synchronous write port and one
// registered read port with read enable. Only the read register is reset.
module fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     re_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port: array contents are intentionally never reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; holds its value when no read is enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= {WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo.sv
// Circular-buffer FIFO with DEPTH-1 usable slots; pointers, occupancy count and
// flags live here, storage and the registered read data live in fifo_ram.
module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH)-1:0] count,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);
  localparam logic [AW-1:0] ONE     = AW'(1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] count_q, count_d;
  logic          wr_ok, rd_ok;

  // Acceptance is judged on the pre-edge flags, so a simultaneous rd/wr on an
  // empty (or full) FIFO only accepts the write (or the read).
  always_comb begin
    wr_ok   = wr && !full;
    rd_ok   = rd && !empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr_ok) begin
      wptr_d = wptr_q + ONE;
    end else begin
      wptr_d = wptr_q;
    end
    if (rd_ok) begin
      rptr_d = rptr_q + ONE;
    end else begin
      rptr_d = rptr_q;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE;
      2'b01:   count_d = count_q - ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
      count_q <= {AW{1'b0}};
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign empty = (count_q == {AW{1'b0}});
  assign full  = (count_q == CNT_MAX);

  fifo_ram #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .we_i   (wr_ok),
    .waddr_i(wptr_q),
    .wdata_i(din),
    .re_i   (rd_ok),
    .raddr_i(rptr_q),
    .rdata_o(dout)
  );

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based model.
module tb_fifo;

  localparam int W = 32;
  localparam int D = 32;
  localparam int CAP = D - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         empty, full;
  logic [4:0]   count;
  logic         rd, wr;
  logic [W-1:0] dout, din;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] model_dout;

  fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk  (clk),
    .rst  (rst),
    .empty(empty),
    .full (full),
    .count(count),
    .rd   (rd),
    .dout (dout),
    .wr   (wr),
    .din  (din)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue; reads pop into dout, writes push.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      automatic bit was_empty = (model_q.size() == 0);
      automatic bit was_full  = (model_q.size() == CAP);
      if (rd && !was_empty) model_dout = model_q.pop_front();
      if (wr && !was_full)  model_q.push_back(din);
    end
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    check("cmp_count", 32'(count), 32'(model_q.size()));
    check("cmp_empty", 32'(empty), 32'(model_q.size() == 0));
    check("cmp_full",  32'(full),  32'(model_q.size() == CAP));
    check("cmp_dout",  dout, model_dout);
  end

  task automatic step(input logic r, input logic w, input logic [W-1:0] d);
    rd = r; wr = w; din = d;
    @(posedge clk);
    #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic fill_drain(input int base, input string tag);
    for (int i = 0; i < CAP; i++) begin
      step(1'b0, 1'b1, W'(base + i));
      check({tag, "_fill_count"}, 32'(count), 32'(i + 1));
      check({tag, "_fill_full"},  32'(full),  32'(i == CAP - 1));
      check({tag, "_fill_empty"}, 32'(empty), 32'd0);
    end
    for (int i = 0; i < CAP; i++) begin
      step(1'b1, 1'b0, '0);
      check({tag, "_drain_dout"},  dout, 32'(base + i));
      check({tag, "_drain_count"}, 32'(count), 32'(CAP - 1 - i));
    end
    check({tag, "_drain_empty"}, 32'(empty), 32'd1);
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout",  dout, 32'd0);

    // Fill 0..30, overflow with 99, drain.
    for (int i = 0; i < CAP; i++) begin
      step(1'b0, 1'b1, W'(i));
      check("fill_count", 32'(count), 32'(i + 1));
      check("fill_full",  32'(full),  32'(i == 30));
      check("fill_empty", 32'(empty), 32'd0);
    end
    step(1'b0, 1'b1, 32'd99);
    check("ovf_count", 32'(count), 32'd31);
    check("ovf_full",  32'(full),  32'd1);
    for (int i = 0; i < CAP; i++) begin
      step(1'b1, 1'b0, '0);
      check("drain_dout",  dout, 32'(i));
      check("drain_count", 32'(count), 32'(30 - i));
    end
    check("drain_empty", 32'(empty), 32'd1);
    step(1'b1, 1'b0, '0);
    check("underflow_dout",  dout, 32'd30);
    check("underflow_count", 32'(count), 32'd0);

    for (int k = 0; k < 3; k++) fill_drain(0, "wrap");

    // Simultaneous read/write with 5 words stored.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, W'(100 + i));
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, W'(200 + i));
      check("simul_count", 32'(count), 32'd5);
      check("simul_dout",  dout, (i < 5) ? 32'(100 + i) : 32'(200 + i - 5));
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, '0);
      check("simul_tail", dout, 32'(205 + i));
    end

    // Simultaneous while empty: only the write lands, no bypass.
    step(1'b1, 1'b1, 32'd300);
    check("simul_empty_count", 32'(count), 32'd1);
    check("simul_empty_dout",  dout, 32'd209);
    step(1'b1, 1'b0, '0);
    check("simul_empty_read", dout, 32'd300);

    // Simultaneous while full: only the read lands.
    for (int i = 0; i < CAP; i++) step(1'b0, 1'b1, W'(400 + i));
    step(1'b1, 1'b1, 32'd500);
    check("simul_full_count", 32'(count), 32'd30);
    check("simul_full_dout",  dout, 32'd400);

    // Asynchronous reset mid-operation discards contents.
    #2 rst = 1'b1;
    #1;
    check("async_rst_count", 32'(count), 32'd0);
    check("async_rst_empty", 32'(empty), 32'd1);
    check("async_rst_dout",  dout, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b0, 1'b1, 32'd7);
    check("post_rst_count", 32'(count), 32'd1);
    step(1'b1, 1'b0, '0);
    check("post_rst_dout", dout, 32'd7);

    // Randomized traffic with shifting read/write bias and rare resets.
    for (int c = 0; c < 3000; c++) begin
      automatic int phase = (c / 250) % 4;
      automatic int pw = (phase == 0) ? 80 : (phase == 1) ? 20 : 50;
      automatic int pr = (phase == 0) ? 20 : (phase == 1) ? 80 : 50;
      if (phase == 3) begin pw = 95; pr = 95; end
      rst = ($urandom_range(0, 599) == 0);
      step($urandom_range(0, 99) < pr, $urandom_range(0, 99) < pw, $urandom);
      rst = 1'b0;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
